// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings and FSM state type for the memory access unit
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } state_t;

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// rtl/mem_access_unit_load_formatter.sv - load lane extraction and sign/zero extension
// Ports: word (RAM word), addr (byte offset), size, is_unsigned -> result (32-bit extended load)
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[7:0];
        case (addr)
            2'b00:   lane_b = word[7:0];
            2'b01:   lane_b = word[15:8];
            2'b10:   lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = 32'h0;
        case (size)
            SZ_BYTE: result = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SZ_HALF: result = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            SZ_WORD: result = word;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store unit driving a fixed-latency data RAM
// Ports: req_* (CPU request, ready only in IDLE), resp_* (one-cycle completion pulse),
//        ram_* (data RAM enable, byte write enables, word address, replicated write data, read data)
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int READ_LAT = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    // WAIT counts down from READ_LAT-1 so it lasts exactly READ_LAT cycles
    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  cnt;
    logic        r_we;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        legal;
    logic [3:0]  lane_we;
    logic [31:0] load_data;

    always_comb begin
        legal = 1'b0;
        case (req_size)
            SZ_BYTE: legal = 1'b1;
            SZ_HALF: legal = ~req_addr[0];
            SZ_WORD: legal = (req_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        lane_we   = 4'b0000;
        ram_wdata = r_wdata;
        case (r_size)
            SZ_BYTE: begin
                lane_we   = 4'b0001 << r_addr[1:0];
                ram_wdata = {4{r_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_we   = r_addr[1] ? 4'b1100 : 4'b0011;
                ram_wdata = {2{r_wdata[15:0]}};
            end
            SZ_WORD: begin
                lane_we   = 4'b1111;
                ram_wdata = r_wdata;
            end
            default: begin
                lane_we   = 4'b0000;
                ram_wdata = r_wdata;
            end
        endcase
    end

    assign ram_addr   = {r_addr[31:2], 2'b00};
    assign resp_valid = (state == RESP);

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nx = legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                ram_en = 1'b1;
                if (r_we) begin
                    ram_we   = lane_we;
                    state_nx = RESP;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_nx = RESP;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    load_formatter u_load_formatter (
        .word        (ram_rdata),
        .addr        (r_addr[1:0]),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .result      (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_unsigned <= req_unsigned;
                        r_size     <= req_size;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        resp_err   <= ~legal;
                        resp_rdata <= 32'h0;
                    end
                end
                ACCESS: begin
                    cnt <= CNT_INIT;
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        resp_rdata <= load_data;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    // Leaving RESP: drop response fields so they only carry data alongside resp_valid
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit (READ_LAT 1 and 3)
module tb_mem_access_unit;

    localparam logic [31:0] JUNK = 32'h5A5A5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] ram_word = 32'h0;

    logic        rdy1, rv1, err1, en1;
    logic [31:0] rd1, addr1, wd1, rr1;
    logic [3:0]  we1;
    logic        rdy3, rv3, err3, en3;
    logic [31:0] rd3, addr3, wd3, rr3;
    logic [3:0]  we3;

    logic [31:0] p1, p3a, p3b, p3c;

    int checks = 0;
    int failures = 0;

    int          lat1, lat3, pulses1, pulses3;
    logic [31:0] data1, data3;
    logic        e1, e3, any_en, acc_en, acc_rdy;
    logic [3:0]  acc_we;
    logic [31:0] acc_addr, acc_wdata;

    always #5 clk = ~clk;

    mem_access_unit #(.READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .ram_en(en1), .ram_we(we1),
        .ram_addr(addr1), .ram_wdata(wd1), .ram_rdata(rr1)
    );

    mem_access_unit #(.READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3), .ram_en(en3), .ram_we(we3),
        .ram_addr(addr3), .ram_wdata(wd3), .ram_rdata(rr3)
    );

    // RAM models: the word is only present exactly READ_LAT cycles after the enable edge
    always @(posedge clk) begin
        p1  <= en1 ? ram_word : JUNK;
        p3a <= en3 ? ram_word : JUNK;
        p3b <= p3a;
        p3c <= p3b;
    end
    assign rr1 = p1;
    assign rr3 = p3c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] word);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; ram_word = word;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat1 = 0; lat3 = 0; pulses1 = 0; pulses3 = 0;
        data1 = 32'hx; data3 = 32'hx; e1 = 1'bx; e3 = 1'bx; any_en = 1'b0;
        acc_en = en1; acc_rdy = rdy1; acc_we = we1; acc_addr = addr1; acc_wdata = wd1;
        for (int c = 1; c <= 12; c++) begin
            any_en = any_en | en1 | en3;
            if (rv1) begin
                pulses1++;
                if (lat1 == 0) begin lat1 = c; data1 = rd1; e1 = err1; end
            end
            if (rv3) begin
                pulses3++;
                if (lat3 == 0) begin lat3 = c; data3 = rd3; e3 = err3; end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready1", 32'(rdy1), 32'd1);
        chk("rst_ready3", 32'(rdy3), 32'd1);
        chk("rst_valid", 32'(rv1), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst_rdata", rd1, 32'h0);
        chk("rst_en", 32'(en1), 32'd0);
        chk("rst_we", 32'(we1), 32'd0);
        chk("rst_addr", addr1, 32'h0);
        chk("rst_wdata", wd1, 32'h0);
        rst = 1'b0;

        // SW 0x10
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0);
        chk("sw_en", 32'(acc_en), 32'd1);
        chk("sw_busy_ready", 32'(acc_rdy), 32'd0);
        chk("sw_we", 32'(acc_we), 32'hF);
        chk("sw_addr", acc_addr, 32'h10);
        chk("sw_wdata", acc_wdata, 32'hDEADBEEF);
        chk("sw_lat1", lat1, 2);
        chk("sw_lat3", lat3, 2);
        chk("sw_err", 32'(e1), 32'd0);
        chk("sw_rdata", data1, 32'h0);
        chk("sw_pulses", pulses1, 1);

        // SB 0x13
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, 32'h0);
        chk("sb_we", 32'(acc_we), 32'h8);
        chk("sb_addr", acc_addr, 32'h10);
        chk("sb_wdata", acc_wdata, 32'hA5A5A5A5);

        // SH 0x22
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 32'h0);
        chk("sh_we", 32'(acc_we), 32'hC);
        chk("sh_addr", acc_addr, 32'h20);
        chk("sh_wdata", acc_wdata, 32'h12341234);

        // LB / LBU 0x11
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h123480FF);
        chk("lb_we", 32'(acc_we), 32'h0);
        chk("lb_en", 32'(acc_en), 32'd1);
        chk("lb_addr", acc_addr, 32'h10);
        chk("lb_lat1", lat1, 3);
        chk("lb_data1", data1, 32'hFFFFFF80);
        chk("lb_lat3", lat3, 5);
        chk("lb_data3", data3, 32'hFFFFFF80);
        chk("lb_pulses3", pulses3, 1);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h123480FF);
        chk("lbu_data1", data1, 32'h00000080);
        chk("lbu_data3", data3, 32'h00000080);

        // LH / LHU 0x12
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h800155AA);
        chk("lh_data1", data1, 32'hFFFF8001);
        chk("lh_data3", data3, 32'hFFFF8001);
        chk("lh_lat3", lat3, 5);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h800155AA);
        chk("lhu_data1", data1, 32'h00008001);
        chk("lhu_data3", data3, 32'h00008001);

        // LH lower lane, LW aligned
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h800155AA);
        chk("lh_lo_data1", data1, 32'h000055AA);
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hCAFEF00D);
        chk("lw_data1", data1, 32'hCAFEF00D);
        chk("lw_data3", data3, 32'hCAFEF00D);

        // Misaligned LW 0x06
        do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h11111111);
        chk("lw_mis_lat1", lat1, 1);
        chk("lw_mis_lat3", lat3, 1);
        chk("lw_mis_err", 32'(e1), 32'd1);
        chk("lw_mis_rdata", data1, 32'h0);
        chk("lw_mis_no_en", 32'(any_en), 32'd0);

        // Odd half and size 11
        do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF, 32'h0);
        chk("sh_odd_err", 32'(e3), 32'd1);
        chk("sh_odd_no_en", 32'(any_en), 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0);
        chk("sz11_err", 32'(e1), 32'd1);
        chk("sz11_lat", lat1, 1);

        // Reset during WAIT of a load
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h11; ram_word = 32'h123480FF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("wrst_ready1", 32'(rdy1), 32'd1);
        chk("wrst_ready3", 32'(rdy3), 32'd1);
        chk("wrst_valid", 32'(rv1 | rv3), 32'd0);
        chk("wrst_err", 32'(err1 | err3), 32'd0);
        chk("wrst_rdata", rd1 | rd3, 32'h0);
        chk("wrst_en", 32'(en1 | en3), 32'd0);
        chk("wrst_we", 32'(we1 | we3), 32'd0);
        chk("wrst_addr", addr1 | addr3, 32'h0);
        chk("wrst_wdata", wd1 | wd3, 32'h0);
        pulses1 = 0;
        for (int c = 0; c < 8; c++) begin
            if (rv1 | rv3) pulses1++;
            @(posedge clk);
            #1;
        end
        chk("wrst_no_resp", pulses1, 0);

        // Unit still usable after the mid-flight reset
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h9A000000);
        chk("post_rst_data1", data1, 32'h0000009A);
        chk("post_rst_lat1", lat1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter READ_LAT, default 1, data-RAM read latency in cycles (legal 1..3).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  CPU load/store request present.
REQ-005 req_ready  out  1  unit accepts request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  address/size error, valid with resp_valid.
REQ-014 ram_en  out  1  data-RAM enable.
REQ-015 ram_we  out  4  byte write enables, bit k = byte lane k.
REQ-016 ram_addr  out  32  word-aligned address (req_addr with [1:0]=00).
REQ-017 ram_wdata  out  32  lane-replicated store data.
REQ-018 ram_rdata  in  32  RAM read word, valid READ_LAT cycles after the ACCESS-cycle edge.

Function
REQ-019 FSM states IDLE, ACCESS, WAIT, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE: req_valid=1 registers all req_* fields; next ACCESS if legal, else RESP with error.
REQ-021 Illegal: size 11; half with addr[0]=1; word with addr[1:0]!=00; no RAM access occurs.
REQ-022 ACCESS: ram_en=1, ram_addr driven; store -> ram_we per REQ-024, next RESP; load -> ram_we=0000, next WAIT.
REQ-023 ram_en=0, ram_we=0000 in every state other than ACCESS.
REQ-024 Little-endian lanes: byte -> we bit addr[1:0]; half -> 0011 (addr[1]=0) or 1100; word -> 1111.
REQ-025 ram_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-026 WAIT lasts exactly READ_LAT cycles (counter); ram_rdata captured at final WAIT edge, extracted and extended, then RESP.
REQ-027 Load extract: byte lane addr[1:0], half lane addr[1]; sign- or zero-extended to 32 per req_unsigned.
REQ-028 RESP: resp_valid=1 for exactly one cycle, outputs registered; next IDLE; no backpressure.
REQ-029 Latency from accept edge to resp_valid: store 2 cycles, load 2+READ_LAT, error 1.
REQ-030 req_valid outside IDLE is ignored; held request accepted only once unit returns to IDLE.

Reset
REQ-031 rst=1 at an edge forces IDLE, clears counter and captured request, from any state.
REQ-032 After reset edge: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_en=0, ram_we=0000, ram_addr=0, ram_wdata=0.
REQ-033 Transaction in flight at reset is dropped; no resp_valid is ever produced for it.

Structure
REQ-034 Shared package mem_pkg holds size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state enum.
REQ-035 Combinational sub-module load_formatter (word, addr[1:0], size, unsigned -> 32-bit result) implements REQ-027.

Verification
REQ-036 SW addr 0x10 data 0xDEADBEEF -> ACCESS: ram_we=1111, ram_addr=0x10, ram_wdata=0xDEADBEEF; resp_valid accept+2, err=0, rdata=0.
REQ-037 SB addr 0x13 data 0x000000A5 -> ram_we=1000, ram_addr=0x10, ram_wdata=0xA5A5A5A5.
REQ-038 LB addr 0x11, RAM word 0x123480FF, READ_LAT=1 -> rdata 0xFFFFFF80 at accept+3; LBU -> 0x00000080.
REQ-039 LH addr 0x12, RAM word 0x800155AA -> 0xFFFF8001; LHU -> 0x00008001; repeat with READ_LAT=3, resp at accept+5.
REQ-040 LW addr 0x06 -> resp_err=1, rdata=0 at accept+1; ram_en never asserted.
REQ-041 rst pulsed during WAIT of a load -> next cycle req_ready=1, outputs per REQ-032, no resp_valid follows.
